fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Receiving end of the fetch-stage output interface (pc, inst, page_fault, cause, tval): buffers fetch packets and presents them to decode with a valid/ready handshake.
- Decouples fetch from decode back-pressure.
- Drops wrong-path packets on redirect (branch/jump or trap flush).
- Sits between the fetch stage and the decode stage of the core pipeline.

Parameters:
DEPTH, 4, number of packet entries; power of two, >= 2
PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden)

Ports:
clk  input  1  core clock
rst_n  input  1  reset, synchronous, active-low
flush  input  1  redirect (bj_en | trap_en from later stage); discards all contents
in_valid  input  1  fetch presents a packet (fetch deasserts on invalid/stall)
in_ready  output  1  queue accepts a packet this cycle
in_pc  input  64  packet pc
in_inst  input  32  packet instruction word
in_page_fault  input  1  instruction fetch page fault
in_cause  input  5  exception cause, meaningful when in_page_fault=1
in_tval  input  64  trap value, meaningful when in_page_fault=1
out_valid  output  1  head packet valid to decode
out_ready  input  1  decode consumes head packet
out_pc  output  64  head pc
out_inst  output  32  head instruction
out_page_fault  output  1  head fault flag
out_cause  output  5  head cause
out_tval  output  64  head tval
count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- All state updates on posedge clk. rst_n=0 sampled at an edge clears wr_ptr, rd_ptr, count, fault_lock to 0. Reset mid-operation discards contents exactly like flush.
- After reset: out_valid=0, count=0, in_ready=1, out_* data=0 (entry array reset to 0).
- enq = in_valid & in_ready. deq = out_valid & out_ready.
- in_ready = (count != DEPTH) & ~fault_lock. Combinational; does not depend on out_ready (no pass-through when full).
- out_valid = (count != 0). out_* read combinationally from entry[rd_ptr].
- Latency: a packet enqueued at edge N is visible on out_* after edge N; decode may consume it in cycle N+1. No same-cycle bypass from in_* to out_*.
- enq: entry[wr_ptr] <= in_*; wr_ptr increments and wraps modulo DEPTH.
- deq: rd_ptr increments and wraps modulo DEPTH.
- count: +1 on enq only; -1 on deq only; unchanged on both or neither.
- Simultaneous enq and deq while full: impossible, since in_ready=0.
- Simultaneous enq and deq while empty: impossible, since out_valid=0.
- fault_lock:
  - Set on enq with in_page_fault=1. Further enqueues are blocked, because packets after a faulting fetch are wrong-path.
  - The faulting packet still drains to decode normally.
  - Cleared only by flush or reset.
- flush (priority over enq/deq): at the edge, wr_ptr=rd_ptr=count=0 and fault_lock=0. A same-cycle in_valid packet is dropped, and a same-cycle deq is still considered taken by decode. out_valid=0 from the next cycle.
- Pointer arithmetic uses PTR_W bits with natural wrap; count is PTR_W+1 bits so that DEPTH is representable.
- Entry data is not cleared on flush; only out_valid qualifies it.

Optional Feature:
IFQ_TRACE_EN:
- Defined: simulation-only $display on every clock edge with rst_n=1 where enq, deq or flush occurs. Each line carries $time, event (ENQ/DEQ/FLUSH), pc (%08x), inst, page_fault, cause, tval and count.
- Undefined: no display code compiled.
- RTL behaviour is identical either way.

Test Plan:
- Reset, then in_valid=1 pc=0x80000000 inst=0x00000013 for 1 cycle with out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, out_inst=0x00000013, count=1, in_ready=1.
- Enqueue 4 packets pc=0x1000,0x1004,0x1008,0x100c with out_ready=0 -> count=4, in_ready=0, 5th in_valid ignored. Then out_ready=1 -> dequeue order 0x1000..0x100c, out_valid=0 after the 4th.
- Continuous in_valid and out_ready for 20 cycles, pc incrementing by 4 -> count holds at 1 and every pc arrives in order across pointer wrap.
- Queue at count=3, assert flush with in_valid=1 pc=0x2000 -> next cycle count=0, out_valid=0. The following enqueue of pc=0x3000 appears as head.
- Enqueue pc=0x4000 with in_page_fault=1 cause=12 tval=0x4000 -> in_ready=0 afterwards. Head shows out_page_fault=1, out_cause=12, out_tval=0x4000. After deq, in_ready stays 0 until flush, then returns to 1.
- rst_n=0 for 1 cycle with count=2 -> count=0, out_valid=0, in_ready=1 on the following cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode packet queue; optional event trace under IFQ_TRACE_EN
module fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_page_fault,
  input  logic [4:0]       in_cause,
  input  logic [63:0]      in_tval,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_page_fault,
  output logic [4:0]       out_cause,
  output logic [63:0]      out_tval,
  output logic [PTR_W:0]   count
);

  localparam int ENTRY_W = 64 + 32 + 1 + 5 + 64;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               fault_lock_q, fault_lock_d;
  logic [ENTRY_W-1:0] entry_q [DEPTH];
  logic [ENTRY_W-1:0] entry_d [DEPTH];
  logic               enq, deq;

  // Handshake and head presentation; in_ready never looks at out_ready
  always_comb begin
    in_ready  = (count_q != FULL_CNT) && !fault_lock_q;
    out_valid = (count_q != '0);
    enq       = in_valid && in_ready;
    deq       = out_valid && out_ready;
    count     = count_q;
    {out_pc, out_inst, out_page_fault, out_cause, out_tval} = entry_q[rd_ptr_q];
  end

  // Next-state: flush wins over enq/deq; a faulting packet locks out later wrong-path fetches
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fault_lock_d = fault_lock_q;
    entry_d      = entry_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      fault_lock_d = 1'b0;
    end else begin
      if (enq) begin
        entry_d[wr_ptr_q] = {in_pc, in_inst, in_page_fault, in_cause, in_tval};
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        if (in_page_fault) begin
          fault_lock_d = 1'b1;
        end
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register; reset also clears entry data so the idle head reads as zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fault_lock_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fault_lock_q <= fault_lock_d;
      entry_q      <= entry_d;
    end
  end

`ifdef IFQ_TRACE_EN
  // Simulation trace of every enqueue, dequeue and flush
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        $display("%0t FLUSH pc=%08x inst=%08x pf=%0d cause=%0d tval=%016x count=%0d",
                 $time, in_pc, in_inst, in_page_fault, in_cause, in_tval, count_q);
      end
      if (enq && !flush) begin
        $display("%0t ENQ pc=%08x inst=%08x pf=%0d cause=%0d tval=%016x count=%0d",
                 $time, in_pc, in_inst, in_page_fault, in_cause, in_tval, count_q);
      end
      if (deq) begin
        $display("%0t DEQ pc=%08x inst=%08x pf=%0d cause=%0d tval=%016x count=%0d",
                 $time, out_pc, out_inst, out_page_fault, out_cause, out_tval, count_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard testbench for fetch_queue
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      in_pc = '0;
  logic [31:0]      in_inst = '0;
  logic             in_page_fault = 1'b0;
  logic [4:0]       in_cause = '0;
  logic [63:0]      in_tval = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_page_fault;
  logic [4:0]       out_cause;
  logic [63:0]      out_tval;
  logic [PTR_W:0]   count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_page_fault(in_page_fault),
    .in_cause(in_cause), .in_tval(in_tval),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_page_fault(out_page_fault),
    .out_cause(out_cause), .out_tval(out_tval),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        pf;
    logic [4:0]  cause;
    logic [63:0] tval;
  } pkt_t;

  // Reference model: an ordered list of accepted packets plus the fault lock bit
  pkt_t exp_q[$];
  bit   lock = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is updated at the edge from the spec rules
  task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic pf, input logic [4:0] cause, input logic [63:0] tval,
                       input logic rdy, input logic fl, input logic rst);
    bit   pred_enq;
    pkt_t p;
    @(negedge clk);
    rst_n = ~rst; flush = fl; in_valid = v; in_pc = pc; in_inst = inst;
    in_page_fault = pf; in_cause = cause; in_tval = tval; out_ready = rdy;
    pred_enq = v && (exp_q.size() < DEPTH) && !lock;
    p.pc = pc; p.inst = inst; p.pf = pf; p.cause = cause; p.tval = tval;
    @(posedge clk);
    if (rst || fl) begin
      exp_q.delete();
      lock = 1'b0;
    end else if (pred_enq) begin
      exp_q.push_back(p);
      if (pf) lock = 1'b1;
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [63:0] pc, input logic rdy);
    cycle(1'b1, pc, 32'h00000013, 1'b0, 5'd0, 64'h0, rdy, 1'b0, 1'b0);
  endtask

  // Monitor: status every cycle, head packet popped and compared on each handshake
  always begin
    pkt_t p;
    @(negedge clk);
    #2;
    if (mon_en && rst_n) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'((exp_q.size() < DEPTH) && !lock));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_spurious: got pc %h expected no packet at %0t", out_pc, $time);
        end else begin
          p = exp_q.pop_front();
          chk("out_pc", out_pc, p.pc);
          chk("out_inst", 64'(out_inst), 64'(p.inst));
          chk("out_page_fault", 64'(out_page_fault), 64'(p.pf));
          chk("out_cause", 64'(out_cause), 64'(p.cause));
          chk("out_tval", out_tval, p.tval);
        end
      end
    end
  end

  initial begin
    logic [63:0] rpc;

    // Reset state
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_tval", out_tval, 64'd0);
    mon_en = 1'b1;

    // Single packet, one-edge latency
    push(64'h80000000, 1'b0);
    #1;
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_pc", out_pc, 64'h80000000);
    chk("t1_out_inst", 64'(out_inst), 64'h00000013);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1);

    // Fill to full, fifth offer ignored, then drain in order
    for (int i = 0; i < 4; i++) push(64'h1000 + 64'(4 * i), 1'b0);
    #1;
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    push(64'h1010, 1'b0);
    #1;
    chk("t2_count_after5", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    #1;
    chk("t2_out_valid_drained", 64'(out_valid), 64'd0);

    // Streaming across pointer wrap
    for (int i = 0; i < 20; i++) begin
      push(64'h5000 + 64'(4 * i), 1'b1);
      #1;
      chk("t3_count_steady", 64'(count), 64'd1);
    end
    idle(1'b1);

    // Flush with a same-cycle offer
    for (int i = 0; i < 3; i++) push(64'h1800 + 64'(4 * i), 1'b0);
    cycle(1'b1, 64'h2000, 32'h13, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("t4_count_flush", 64'(count), 64'd0);
    chk("t4_out_valid_flush", 64'(out_valid), 64'd0);
    push(64'h3000, 1'b0);
    #1;
    chk("t4_head_pc", out_pc, 64'h3000);
    idle(1'b1);

    // Page fault locks the queue until flush
    cycle(1'b1, 64'h4000, 32'h0, 1'b1, 5'd12, 64'h4000, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t5_in_ready_locked", 64'(in_ready), 64'd0);
    chk("t5_head_pf", 64'(out_page_fault), 64'd1);
    chk("t5_head_cause", 64'(out_cause), 64'd12);
    chk("t5_head_tval", out_tval, 64'h4000);
    push(64'h4004, 1'b1);
    push(64'h4008, 1'b1);
    #1;
    chk("t5_in_ready_after_deq", 64'(in_ready), 64'd0);
    chk("t5_out_valid_after_deq", 64'(out_valid), 64'd0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("t5_in_ready_flushed", 64'(in_ready), 64'd1);

    // Reset mid-operation
    push(64'h6000, 1'b0);
    push(64'h6004, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);

    // Randomized traffic against the model
    rpc = 64'h8000_0000;
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 99) < 70, rpc, $urandom(),
            $urandom_range(0, 99) < 5, 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4,
            $urandom_range(0, 199) == 0);
      rpc = rpc + 64'd4;
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    #1;
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
